apb_master_arbiter: RTL
=======================

// Module: apb_master_arbiter
// PURPOSE
// - Shares one APB master port between two requesters (RX-side and TX-side config agents).
// - Round-robin arbitration; sequences the APB IDLE/SETUP/ACCESS protocol; returns rdata/err to the winner.
// - Sits between the aligner-core config requesters and the APB slave register block.
// PARAMETERS
// - ADDR_WIDTH      16  paddr / reqN_addr width
// - DATA_WIDTH      32  pwdata / prdata / reqN_wdata / rspN_rdata width
// - TIMEOUT_CYCLES  16  ACCESS cycles with pready=0 before abort (used only with AY_APB_TIMEOUT_EN)
// PORTS
// - clk         in   1           clock, rising edge
// - preset_n    in   1           synchronous active-low reset
// - reqN_valid  in   1           N=0,1: command valid; write/addr/wdata held stable until reqN_ready
// - reqN_ready  out  1           N=0,1: command accepted this cycle (combinational)
// - reqN_write  in   1           N=0,1: 1=write, 0=read
// - reqN_addr   in   ADDR_WIDTH  N=0,1: target address
// - reqN_wdata  in   DATA_WIDTH  N=0,1: write data
// - rspN_valid  out  1           N=0,1: one-cycle completion pulse
// - rspN_rdata  out  DATA_WIDTH  N=0,1: read data (0 for writes)
// - rspN_err    out  1           N=0,1: pslverr (or timeout) captured at completion
// - paddr/pwrite/psel/penable/pwdata  out  ADDR_WIDTH/1/1/1/DATA_WIDTH  APB master outputs
// - pready/prdata/pslverr             in   1/DATA_WIDTH/1               APB slave responses
// BEHAVIOUR
// - Reset (preset_n=0 at clk edge): state IDLE; every output 0; last_grant=1 (req0 wins first tie).
// - Arbitration: one valid -> it wins; both valid -> the one NOT equal to last_grant wins.
// - Arbitration points: IDLE, and the ACCESS cycle where pready=1 (completion).
// - Winner gets reqN_ready=1 that cycle; cmd latched; last_grant updated; next state SETUP.
// - FSM:
//   - IDLE:   psel=0, penable=0; grant -> SETUP, else stay.
//   - SETUP:  psel=1, penable=0, paddr/pwrite/pwdata = latched cmd; always -> ACCESS next cycle.
//   - ACCESS: psel=1, penable=1, APB outputs stable; pready=0 -> stay.
//   - ACCESS, pready=1 -> completion:
//     - rspN_valid=1 next cycle (registered) to the owner.
//     - rspN_rdata = prdata if read, else 0; rspN_err = pslverr.
//     - New grant same cycle -> SETUP (back-to-back, psel stays 1); else -> IDLE.
// - Latency: grant-to-rsp_valid = 3 cycles with zero-wait slave; +1 per pready=0 cycle.
// - Back-to-back throughput: one transfer per 2 cycles.
// - rspN_valid/rdata/err are single-cycle; rdata/err return to 0 when rspN_valid=0.
// - Only the granted owner ever sees rsp; never both rsp0_valid and rsp1_valid in one cycle.
// - reqN_valid dropping before ready: request silently withdrawn, no rsp.
// - Reset mid-transfer: psel/penable=0 at that edge, latched cmd discarded, no rsp, last_grant=1.
// - pready/prdata/pslverr ignored outside ACCESS.
// CONFIGURATION
// - AY_APB_TIMEOUT_EN defined:
//   - Counter increments each ACCESS cycle with pready=0; cleared on entering SETUP.
//   - At count == TIMEOUT_CYCLES: forced completion, rspN_err=1, rspN_rdata=0, same next-state rules.
// - AY_APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.
// TESTING
// - req0 read 0x0010, slave pready=1 first ACCESS, prdata=0xDEADBEEF
//   -> psel cycles 2..3, rsp0_valid 3 cycles after grant, rsp0_rdata=0xDEADBEEF, err=0.
// - req0+req1 valid together after reset, both writes (0x0004/0x11, 0x0008/0x22)
//   -> req0 granted first; req1 granted at req0 completion; psel held 1; rsp1 2 cycles after rsp0.
// - req1 held valid continuously, req0 pulsed valid -> grants alternate 0,1,0,1 (no starvation).
// - Write 0x0020 with 3 pready=0 cycles, then pready=1 with pslverr=1
//   -> penable high 4 cycles, rsp_valid with rsp_err=1, rsp_rdata=0.
// - preset_n=0 during ACCESS -> next edge psel=penable=0, no rsp pulse, following tie grants req0.
// - AY_APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0
//   -> abort after 16 wait cycles, rsp_err=1, rdata=0, FSM to IDLE.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin share of one APB master port between two
// requesters; runs IDLE/SETUP/ACCESS and returns rdata/err to the winner.
// Ports: clk, preset_n (sync active-low); reqN_valid/ready/write/addr/wdata
// (command in); rspN_valid/rdata/err (one-cycle completion out); APB master
// paddr/pwrite/psel/penable/pwdata out, pready/prdata/pslverr in.
// Optional: define AY_APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  preset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic                  owner;
  logic                  timeout;
  logic                  done;
  logic                  arb_pt;
  logic                  grant0;
  logic                  grant1;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  // Both valid: the requester that did not win last time goes next.
  always_comb begin
    done     = (state == ACCESS) && (pready || timeout);
    arb_pt   = preset_n && ((state == IDLE) || done);
    grant0   = arb_pt && req0_valid && (!req1_valid || last_grant);
    grant1   = arb_pt && req1_valid && (!req0_valid || !last_grant);
    rsp_data = (pwrite || timeout) ? '0 : prdata;
    rsp_err  = pslverr || timeout;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

`ifdef AY_APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  assign timeout = (state == ACCESS) && (cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!preset_n) begin
      cnt <= '0;
    end else if (grant0 || grant1) begin
      cnt <= '0;
    end else if (state == ACCESS && !pready && !timeout) begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!preset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
      if (done) begin
        if (!owner) begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= rsp_data;
          rsp0_err   <= rsp_err;
        end else begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= rsp_data;
          rsp1_err   <= rsp_err;
        end
      end
      // A grant at completion keeps psel high for a back-to-back SETUP.
      if (grant0 || grant1) begin
        state      <= SETUP;
        psel       <= 1'b1;
        penable    <= 1'b0;
        owner      <= grant1;
        last_grant <= grant1;
        paddr      <= grant1 ? req1_addr  : req0_addr;
        pwrite     <= grant1 ? req1_write : req0_write;
        pwdata     <= grant1 ? req1_wdata : req0_wdata;
      end else begin
        unique case (state)
          SETUP: begin
            state   <= ACCESS;
            penable <= 1'b1;
          end
          ACCESS: begin
            if (done) begin
              state   <= IDLE;
              psel    <= 1'b0;
              penable <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
